dmem_responder: RTL

//  Responder end of the core's data-memory request/response channel: accepts one load/store
//  per handshake, performs it on a local word-organised SRAM after WAIT_STATES cycles, and

---
 rtl/dmem_pkg.sv | 87 ++++++++
 rtl/dmem_sram.sv | 41 ++++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   mem_size_e   : RV32I load/store funct3 encodings
//   dmem_state_e : responder FSM states
//   helpers      : funct3 legality, size decode, lane alignment, misalignment,
//                  byte enables, store-data lane replication, load extension
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  function automatic logic funct3_legal(logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  // Illegal encodings fall back to a full-word access.
  function automatic mem_size_e decode_size(logic [2:0] f3);
    return funct3_legal(f3) ? mem_size_e'(f3) : SZ_W;
  endfunction

  // Force the byte lane down to the natural alignment of the access size.
  function automatic logic [1:0] align_lane(mem_size_e sz, logic [1:0] a);
    logic [1:0] lane;
    case (sz)
      SZ_B, SZ_BU: lane = a;
      SZ_H, SZ_HU: lane = {a[1], 1'b0};
      default:     lane = 2'b00;
    endcase
    return lane;
  endfunction

  function automatic logic misaligned(mem_size_e sz, logic [1:0] a);
    logic bad;
    case (sz)
      SZ_B, SZ_BU: bad = 1'b0;
      SZ_H, SZ_HU: bad = a[0];
      default:     bad = (a != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(mem_size_e sz, logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_B, SZ_BU: be = 4'b0001 << lane;
      SZ_H, SZ_HU: be = 4'b0011 << lane;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across all lanes; byte enables pick the target.
  function automatic logic [31:0] store_data(mem_size_e sz, logic [31:0] wdata);
    logic [31:0] d;
    case (sz)
      SZ_B, SZ_BU: d = {4{wdata[7:0]}};
      SZ_H, SZ_HU: d = {2{wdata[15:0]}};
      default:     d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(mem_size_e sz, logic [31:0] word, logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_B:    res = {{24{sh[7]}}, sh[7:0]};
      SZ_BU:   res = {24'h0, sh[7:0]};
      SZ_H:    res = {{16{sh[15]}}, sh[15:0]};
      SZ_HU:   res = {16'h0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH_WORDS x 32 single-port SRAM with byte-enable write and
// synchronous read. Read data stays on rdata_o until the next read.
//   clk      : clock
//   we_i     : write enable, be_i selects lanes
//   re_i     : read enable, rdata_o updates on the following edge
//   be_i     : byte enables (lane 0 = bits 7:0)
//   addr_i   : word index
//   wdata_i  : write data (already placed in its lanes)
//   rdata_o  : registered read data
module dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: storage arrays and their read register carry no reset; resetting a
  // memory turns it into a huge flop bank and the contents are undefined anyway.
  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the data-memory request/response channel.
// Accepts one load/store per handshake, performs it on a local SRAM after
// WAIT_STATES cycles and returns extended load data or a store acknowledge.
// Optional feature macro: DMEM_ERR_RESP_EN (access-fault responses). Without
// it rsp_err is 0, addresses are force-aligned, the word index wraps and
// illegal funct3 acts as a word access.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE, out of reset)
//   req_write/req_funct3  : store flag and RV32I size/sign
//   req_addr/req_wdata    : byte address, right-justified store data
//   rsp_valid/rsp_ready   : response handshake, response held until taken
//   rsp_rdata/rsp_err     : extended load data (0 for stores/faults), fault flag
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import dmem_pkg::*;

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, enter_resp, in_idle;

  // Request decode, done combinationally on the incoming request.
  logic [31:0]   req_off;
  mem_size_e     req_size;
  logic [1:0]    req_lane;
  logic [AW-1:0] req_idx;
  logic          req_err;

  assign req_off  = req_addr - BASE_ADDR;
  assign req_size = decode_size(req_funct3);
  assign req_lane = align_lane(req_size, req_off[1:0]);
  assign req_idx  = req_off[AW+1:2];

`ifdef DMEM_ERR_RESP_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  assign req_err = !funct3_legal(req_funct3)
                || misaligned(req_size, req_off[1:0])
                || ({1'b0, req_off} >= SPAN);
`else
  logic unused_off_bits;
  assign req_err         = 1'b0;
  assign unused_off_bits = ^req_off[31:AW+2];
`endif

  // Latched request, held through WAIT and RESP.
  logic          write_q, err_q;
  mem_size_e     size_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  assign in_idle   = (state_q == IDLE);
  assign req_ready = in_idle && !rst;
  assign accept    = req_valid && req_ready;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload registers only load on accept; state alone says whether they are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      err_q   <= req_err;
      size_q  <= req_size;
      lane_q  <= req_lane;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
    end
  end

  // With no wait states the SRAM access happens on the accept edge itself, so
  // the live request is used while IDLE and the latched copy otherwise.
  logic          cur_write, cur_err;
  mem_size_e     cur_size;
  logic [1:0]    cur_lane;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic          mem_we, mem_re;
  logic [31:0]   mem_rdata;

  assign cur_write = in_idle ? req_write : write_q;
  assign cur_err   = in_idle ? req_err   : err_q;
  assign cur_size  = in_idle ? req_size  : size_q;
  assign cur_lane  = in_idle ? req_lane  : lane_q;
  assign cur_idx   = in_idle ? req_idx   : idx_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;

  // Gating with rst drops a store whose RESP entry coincides with reset.
  assign mem_we = enter_resp && cur_write && !cur_err && !rst;
  assign mem_re = enter_resp && !cur_write && !rst;

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .be_i    (lane_be(cur_size, cur_lane)),
    .addr_i  (cur_idx),
    .wdata_i (store_data(cur_size, cur_wdata)),
    .rdata_o (mem_rdata)
  );

  // Response fields come straight from registers (FSM state, latched request,
  // SRAM read register), so they stay stable while the response is held.
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? load_extend(size_q, mem_rdata, lane_q)
                                                       : 32'h0;

endmodule
